// File: rtl/mesh_link_fabric.sv
// Registered mesh/torus link fabric: one LINK_DEPTH-entry FIFO per directed router-to-router
// link with hold-based backpressure and sticky overflow flags; local port 4 is a straight wire.
module mesh_link_fabric #(
    parameter int unsigned X_NODES    = 3,
    parameter int unsigned Y_NODES    = 3,
    parameter int unsigned FIFO_WIDTH = 632,
    parameter int unsigned LINK_DEPTH = 2,
    parameter int unsigned MODE       = 0
) (
    input  logic                                                   clk,
    input  logic                                                   reset,
    input  logic [X_NODES*Y_NODES-1:0][4:0][FIFO_WIDTH-1:0]        routerOutData,
    input  logic [X_NODES*Y_NODES-1:0][4:0]                        routerOutWriteRequest,
    input  logic [X_NODES*Y_NODES-1:0][4:0]                        routerOutHoldRequest,
    output logic [X_NODES*Y_NODES-1:0][4:0][FIFO_WIDTH-1:0]        routerInData,
    output logic [X_NODES*Y_NODES-1:0][4:0]                        routerInWriteRequest,
    output logic [X_NODES*Y_NODES-1:0][4:0]                        routerInHoldRequest,
    input  logic [X_NODES*Y_NODES-1:0][FIFO_WIDTH-1:0]             nodeToNetworkData,
    input  logic [X_NODES*Y_NODES-1:0]                             nodeToNetworkWriteRequest,
    input  logic [X_NODES*Y_NODES-1:0]                             nodeToNetworkHoldRequest,
    output logic [X_NODES*Y_NODES-1:0][FIFO_WIDTH-1:0]             networkToNodeData,
    output logic [X_NODES*Y_NODES-1:0]                             networkToNodeWriteRequest,
    output logic [X_NODES*Y_NODES-1:0]                             networkToNodeHoldRequest,
    output logic [X_NODES*Y_NODES-1:0][4:0]                        linkOverflow
);

    localparam int unsigned N     = X_NODES * Y_NODES;
    localparam int unsigned PTR_W = (LINK_DEPTH > 1) ? $clog2(LINK_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(LINK_DEPTH + 1);

    // Neighbour of node n through port p, always wrapping; edge links are filtered by has_link.
    function automatic int unsigned nbr(input int unsigned n, input int unsigned p);
        int unsigned x;
        int unsigned y;
        x = n % X_NODES;
        y = n / X_NODES;
        case (p)
            0:       y = (y + 1) % Y_NODES;
            1:       x = (x + 1) % X_NODES;
            2:       y = (y + Y_NODES - 1) % Y_NODES;
            default: x = (x + X_NODES - 1) % X_NODES;
        endcase
        return x + X_NODES * y;
    endfunction

    function automatic bit has_link(input int unsigned n, input int unsigned p);
        int unsigned x;
        int unsigned y;
        x = n % X_NODES;
        y = n / X_NODES;
        if (MODE == 1) return 1'b1;
        case (p)
            0:       return y < Y_NODES - 1;
            1:       return x < X_NODES - 1;
            2:       return y > 0;
            default: return x > 0;
        endcase
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(LINK_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    for (genvar gn = 0; gn < N; gn++) begin : g_node
        for (genvar gp = 0; gp < 4; gp++) begin : g_port
            localparam int unsigned DST = nbr(gn, gp);
            localparam int unsigned QP  = gp ^ 2;

            if (has_link(gn, gp)) begin : g_link
                logic [CNT_W-1:0]      cnt_q, cnt_d;
                logic [PTR_W-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
                logic                  ovf_q, ovf_d;
                logic                  push_c, pop_c, accept_c;
                logic [FIFO_WIDTH-1:0] mem_q [LINK_DEPTH];

                // A full FIFO still accepts when its head leaves in the same cycle.
                always_comb begin
                    push_c   = routerOutWriteRequest[gn][gp];
                    pop_c    = (cnt_q != '0) && !routerOutHoldRequest[DST][QP];
                    accept_c = push_c && ((cnt_q < CNT_W'(LINK_DEPTH)) || pop_c);
                    cnt_d    = cnt_q;
                    wptr_d   = wptr_q;
                    rptr_d   = rptr_q;
                    ovf_d    = ovf_q | (push_c & ~accept_c);
                    if (accept_c) wptr_d = ptr_inc(wptr_q);
                    if (pop_c)    rptr_d = ptr_inc(rptr_q);
                    if (accept_c && !pop_c)      cnt_d = cnt_q + CNT_W'(1);
                    else if (!accept_c && pop_c) cnt_d = cnt_q - CNT_W'(1);
                end

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        cnt_q  <= '0;
                        wptr_q <= '0;
                        rptr_q <= '0;
                        ovf_q  <= 1'b0;
                    end else begin
                        cnt_q  <= cnt_d;
                        wptr_q <= wptr_d;
                        rptr_q <= rptr_d;
                        ovf_q  <= ovf_d;
                    end
                end

                always_ff @(posedge clk) begin
                    if (accept_c) mem_q[wptr_q] <= routerOutData[gn][gp];
                end

                assign routerInData[DST][QP]         = (cnt_q != '0) ? mem_q[rptr_q] : '0;
                assign routerInWriteRequest[DST][QP] = pop_c;
                assign routerInHoldRequest[gn][gp]   = (cnt_q >= CNT_W'(LINK_DEPTH - 1));
                assign linkOverflow[gn][gp]          = ovf_q;
            end else begin : g_edge
                logic ovf_q;
                logic unused_edge;

                assign unused_edge = ^{routerOutData[gn][gp], routerOutHoldRequest[DST][QP]};

                // Open mesh edge: every write is lost and flagged.
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        ovf_q <= 1'b0;
                    end else if (routerOutWriteRequest[gn][gp]) begin
                        ovf_q <= 1'b1;
                    end
                end

                assign routerInData[DST][QP]         = '0;
                assign routerInWriteRequest[DST][QP] = 1'b0;
                assign routerInHoldRequest[gn][gp]   = 1'b0;
                assign linkOverflow[gn][gp]          = ovf_q;
            end
        end

        assign routerInData[gn][4]            = nodeToNetworkData[gn];
        assign routerInWriteRequest[gn][4]    = nodeToNetworkWriteRequest[gn];
        assign routerInHoldRequest[gn][4]     = nodeToNetworkHoldRequest[gn];
        assign networkToNodeData[gn]          = routerOutData[gn][4];
        assign networkToNodeWriteRequest[gn]  = routerOutWriteRequest[gn][4];
        assign networkToNodeHoldRequest[gn]   = routerOutHoldRequest[gn][4];
        assign linkOverflow[gn][4]            = 1'b0;
    end

endmodule

// File: doc/mesh_link_fabric.md
# mesh_link_fabric

Parametrised 2D mesh/torus interconnect that joins X_NODES×Y_NODES routers and buffers every directed inter-router link in a LINK_DEPTH-entry registered FIFO with hold-based backpressure. It is the next generation of the combinational mesh wiring: all link timing is now registered, and link buffer overflow is detected. It sits between the router array and the node interfaces. Local port 4 passes straight through to the node.

## Interface
Parameters:
- X_NODES, 3, mesh columns (≥2 when MODE=1)
- Y_NODES, 3, mesh rows (≥2 when MODE=1)
- FIFO_WIDTH, 632, flit width in bits
- LINK_DEPTH, 2, entries per directed link FIFO (≥2)
- MODE, 0, 0 = mesh with open edges; 1 = torus with wrap-around links

N = X_NODES*Y_NODES; node n = x + X_NODES*y. Ports: 0 → n+X_NODES, 1 → n+1, 2 → n−X_NODES, 3 → n−1, 4 = local.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- routerOutData  in  [N][5]×FIFO_WIDTH  router output flits
- routerOutWriteRequest  in  [N]×5  router output write strobes
- routerOutHoldRequest  in  [N]×5  router input port p cannot accept
- routerInData  out  [N][5]×FIFO_WIDTH  router input flits
- routerInWriteRequest  out  [N]×5  router input write strobes
- routerInHoldRequest  out  [N]×5  output port p of router n must stop writing
- nodeToNetworkData/WriteRequest/HoldRequest  in  [N]×FIFO_WIDTH/1/1  node side
- networkToNodeData/WriteRequest/HoldRequest  out  [N]×FIFO_WIDTH/1/1  node side
- linkOverflow  out  [N]×5  sticky error: a write to the link leaving n on port p was dropped

## Operation
- One FIFO per directed link (src n, port p) → (dst m, opposite port q = p^2 for p∈{0..3}). Occupancy counter 0..LINK_DEPTH; circular read/write pointers mod LINK_DEPTH.
- Push: routerOutWriteRequest[n][p]=1. Accepted if count<LINK_DEPTH, or if count==LINK_DEPTH and a pop occurs in the same cycle. Otherwise the flit is dropped and linkOverflow[n][p] is set until reset.
- routerInHoldRequest[n][p] = (count ≥ LINK_DEPTH−1). It is decoded from registered count, which gives one cycle of slack for a router that registers hold.
- Pop: routerInWriteRequest[m][q] = (count>0) && !routerOutHoldRequest[m][q]. A flit pops on every cycle this is 1. routerInData[m][q] = head entry. Data is don't-care when the write strobe is 0, but must be driven to 0 when the link is empty.
- Simultaneous push and pop: count is unchanged; both pointers advance.
- MODE=0 edge ports (north of top row, port 1 of last column, port 2 of row 0, port 3 of column 0) have no FIFO:
  - routerIn* outputs are 0.
  - routerInHoldRequest is 0.
  - Writes into an edge port are ignored and set linkOverflow for that port.
- MODE=1: edge ports wrap to the opposite row/column, so all 4N links exist.
- Local: routerIn*[n][4] = nodeToNetwork*[n]; networkToNode*[n] = routerOut*[n][4]; routerInHoldRequest[n][4] = nodeToNetworkHoldRequest[n]. All combinational.
- linkOverflow[n][4] is always 0.

## Timing
- Reset values: all counts and pointers 0; linkOverflow 0; routerInWriteRequest 0; routerInHoldRequest 0; routerInData 0 on link ports. The local path follows its inputs.
- Reset asserted mid-transfer empties every FIFO immediately; in-flight flits are lost. The first push is accepted on the first rising edge after reset deassertion.
- Latency: a flit pushed at edge t is presented to the destination router during cycle t+1 (no bypass).
- Throughput: 1 flit/cycle/link sustained while the destination is not held.
- Hold from the destination stalls the FIFO. The source sees routerInHoldRequest rise in the cycle after count reaches LINK_DEPTH−1.

## Test plan
- 3×3 mesh, LINK_DEPTH=2: node 0 port 1 writes flit A at cycle 5 → node 1 port 3 sees write=1 and data=A in cycle 6, for one cycle only.
- Destination hold: node 4 holds port 3 while node 3 streams on port 1 → count reaches 1, then hold rises; a source that honours hold causes no overflow; releasing hold drains flits in order, 1/cycle.
- Source ignores hold: 3 writes with the destination held, LINK_DEPTH=2 → third write dropped, linkOverflow[3][1]=1 and stays set; the first two flits are delivered intact after release.
- Full + simultaneous push/pop: count=2, destination releases hold and source writes in the same cycle → write accepted, count stays 2, no overflow.
- Edges: MODE=0, node 2 writes port 1 → no delivery, linkOverflow[2][1]=1. MODE=1, same write → delivered to node 0 port 3 one cycle later.
- Reset mid-operation: assert reset with 2 flits queued → outputs clear immediately and the queued flits are never delivered.
